bitwise_alu_pipe: RTL and testbench

//   Parametrised, pipelined bitwise/shift unit. Successor to the 32-bit

---
 rtl/bitwise_alu_pipe.sv | 108 ++++++++++
 tb/tb_bitwise_alu_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_alu_pipe.sv
// Two-stage pipelined bitwise/shift/rotate unit with valid/ready on both sides, 1 beat/cycle.
// Define BITWISE_ALU_FLAGS_EN to add registered out_zero / out_parity result flags.
module bitwise_alu_pipe #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef BITWISE_ALU_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_parity
`endif
);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_SHL = 3'b011,
    OP_SHR = 3'b100,
    OP_SRA = 3'b101,
    OP_ROL = 3'b110,
    OP_ROR = 3'b111
  } op_e;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;
  logic [SHW-1:0]   s1_shamt;

  logic s2_adv;
  logic s1_adv;

  // Each stage advances when the one after it is empty or draining.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv && !rst;

  logic [2*WIDTH-1:0] rot_l;
  logic [2*WIDTH-1:0] rot_r;
  logic [WIDTH-1:0]   alu_res;

  always_comb begin
    // Rotates shift a doubled copy so wrapped bits land in the kept half.
    rot_l   = {s1_a, s1_a} << s1_shamt;
    rot_r   = {s1_a, s1_a} >> s1_shamt;
    alu_res = '0;
    case (s1_op)
      OP_AND:  alu_res = s1_a & s1_b;
      OP_OR:   alu_res = s1_a | s1_b;
      OP_XOR:  alu_res = s1_a ^ s1_b;
      OP_SHL:  alu_res = s1_a << s1_shamt;
      OP_SHR:  alu_res = s1_a >> s1_shamt;
      OP_SRA:  alu_res = $signed(s1_a) >>> s1_shamt;
      OP_ROL:  alu_res = rot_l[2*WIDTH-1:WIDTH];
      OP_ROR:  alu_res = rot_r[WIDTH-1:0];
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
`ifdef BITWISE_ALU_FLAGS_EN
      out_zero   <= 1'b0;
      out_parity <= 1'b0;
`endif
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          result <= alu_res;
`ifdef BITWISE_ALU_FLAGS_EN
          out_zero   <= (alu_res == '0);
          out_parity <= ^alu_res;
`endif
        end
      end
    end
  end

  // Operand registers carry no reset; s1_valid qualifies them.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_a     <= a;
      s1_b     <= b;
      s1_op    <= op_e'(op);
      s1_shamt <= shamt;
    end
  end

endmodule

// File: tb/tb_bitwise_alu_pipe.sv
// Bench for bitwise_alu_pipe: directed vector table, randomized stream with scoreboard,
// stall/reset corner sequences, and 8/64-bit width instances.
module tb_bitwise_alu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  op = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;

  logic        v8 = 1'b0, rdy8, ov8;
  logic [7:0]  a8 = '0, b8 = '0, r8;
  logic [2:0]  op8 = '0;
  logic [2:0]  sh8 = '0;
  logic        v64 = 1'b0, rdy64, ov64;
  logic [63:0] a64 = '0, b64 = '0, r64;
  logic [2:0]  op64 = '0;
  logic [5:0]  sh64 = '0;

`ifdef BITWISE_ALU_FLAGS_EN
  logic out_zero, out_parity, z8, p8, z64, p64;
`endif

  bitwise_alu_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
`ifdef BITWISE_ALU_FLAGS_EN
    , .out_zero(out_zero), .out_parity(out_parity)
`endif
  );

  bitwise_alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8),
    .a(a8), .b(b8), .op(op8), .shamt(sh8),
    .out_valid(ov8), .out_ready(1'b1), .result(r8)
`ifdef BITWISE_ALU_FLAGS_EN
    , .out_zero(z8), .out_parity(p8)
`endif
  );

  bitwise_alu_pipe #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(rdy64),
    .a(a64), .b(b64), .op(op64), .shamt(sh64),
    .out_valid(ov64), .out_ready(1'b1), .result(r64)
`ifdef BITWISE_ALU_FLAGS_EN
    , .out_zero(z64), .out_parity(p64)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: each result bit is picked from the source bit it comes from.
  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input int s);
    logic [31:0] r;
    r = '0;
    case (o)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: r = x ^ y;
      default:
        for (int i = 0; i < 32; i++) begin
          case (o)
            3'd3:    r[i] = (i >= s) ? x[i - s] : 1'b0;
            3'd4:    r[i] = (i + s < 32) ? x[i + s] : 1'b0;
            3'd5:    r[i] = (i + s < 32) ? x[i + s] : x[31];
            3'd6:    r[i] = x[(i - s + 32) % 32];
            default: r[i] = x[(i + s) % 32];
          endcase
        end
    endcase
    return r;
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  logic [31:0] drv_exp = '0;
  logic [31:0] exp_q[$];
  int          acc_q[$];
  int          inflight   = 0;
  bit          chk_lat    = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] held       = '0;
  int          rdy_mode   = 0;
  int          pat_i      = 0;

  // out_ready pattern: 0 = always, 1 = 1,0,0,1 repeating, 2 = random, 3 = held low.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = (pat_i % 4 == 0) || (pat_i % 4 == 3);
        pat_i++;
      end
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Scoreboard / protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      inflight   = 0;
      prev_stall = 1'b0;
      check("in_ready_during_reset", 64'(in_ready), 64'(0));
    end else begin
      check("in_ready", 64'(in_ready), 64'(!(inflight == 2 && !out_ready)));
      if (prev_stall) begin
        check("stall_out_valid", 64'(out_valid), 64'(1));
        check("stall_result", 64'(result), 64'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(1), 64'(0));
        end else begin
          logic [31:0] e;
          int          t;
          e = exp_q.pop_front();
          t = acc_q.pop_front();
          check("result", 64'(result), 64'(e));
          if (chk_lat) check("latency", 64'(cyc - t), 64'(2));
`ifdef BITWISE_ALU_FLAGS_EN
          check("out_zero", 64'(out_zero), 64'(e == 0));
          check("out_parity", 64'(out_parity), 64'(^e));
`endif
          inflight--;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(drv_exp);
        acc_q.push_back(cyc);
        inflight++;
      end
      prev_stall = out_valid && !out_ready;
      held       = result;
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [4:0] s, input logic [31:0] e);
    bit got;
    int waited;
    got = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    op = o; a = x; b = y; shamt = s; drv_exp = e;
    while (!got && waited < 50) begin
      @(negedge clk);
      got = in_ready;
      waited++;
      if (!got) begin
        @(posedge clk);
        #1;
      end
    end
    if (!got) check("send_timeout", 64'(0), 64'(1));
    else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || out_valid) && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    logic [4:0]  rs;

    tbl.push_back('{3'b000, 32'hF0F0_00FF, 32'h0FF0_FF00, 5'd0, 32'h00F0_0000});
    tbl.push_back('{3'b001, 32'hF0F0_00FF, 32'h0FF0_FF00, 5'd0, 32'hFFF0_FFFF});
    tbl.push_back('{3'b010, 32'hF0F0_00FF, 32'h0FF0_FF00, 5'd0, 32'hFF00_FFFF});
    tbl.push_back('{3'b011, 32'h8000_0001, 32'h0, 5'd4, 32'h0000_0010});
    tbl.push_back('{3'b100, 32'h8000_0001, 32'h0, 5'd4, 32'h0800_0000});
    tbl.push_back('{3'b101, 32'h8000_0001, 32'h0, 5'd4, 32'hF800_0000});
    tbl.push_back('{3'b110, 32'h8000_0001, 32'h0, 5'd4, 32'h0000_0018});
    tbl.push_back('{3'b111, 32'h8000_0001, 32'h0, 5'd4, 32'h1800_0000});
    for (int k = 3; k < 8; k++)
      tbl.push_back('{3'(k), 32'h8000_0001, 32'hFFFF_FFFF, 5'd0, 32'h8000_0001});
    tbl.push_back('{3'b010, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 5'd0, 32'h0000_0000});
    tbl.push_back('{3'b001, 32'h0000_0001, 32'h0000_0000, 5'd0, 32'h0000_0001});

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_result", 64'(result), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_release", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    chk_lat = 1'b1;
    foreach (tbl[i]) send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, tbl[i].exp);
    drain();
    chk_lat = 1'b0;

    rdy_mode = 1;
    for (int i = 0; i < 10; i++) begin
      ro = 3'($urandom_range(0, 7)); rx = $urandom; ry = $urandom; rs = 5'($urandom_range(0, 31));
      send(ro, rx, ry, rs, ref_op(ro, rx, ry, int'(rs)));
    end
    drain();

    rdy_mode = 2;
    for (int i = 0; i < 200; i++) begin
      ro = 3'($urandom_range(0, 7)); rx = $urandom; ry = $urandom; rs = 5'($urandom_range(0, 31));
      send(ro, rx, ry, rs, ref_op(ro, rx, ry, int'(rs)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 0;
    drain();

    // Reset with two beats in flight: both must vanish.
    rdy_mode = 3;
    @(posedge clk);
    #1;
    send(3'b001, 32'h1234_5678, 32'h0, 5'd0, 32'h1234_5678);
    send(3'b011, 32'h0000_0001, 32'h0, 5'd8, 32'h0000_0100);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    check("rst_release_in_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_beat", 64'(out_valid), 64'(0));
    end

    // Width 8: ROR then SRA of 0x81 by 7.
    @(posedge clk);
    #1;
    v8 = 1'b1; a8 = 8'h81; sh8 = 3'd7; op8 = 3'b111;
    @(posedge clk);
    #1;
    op8 = 3'b101;
    @(posedge clk);
    #1;
    v8 = 1'b0;
    @(negedge clk);
    check("w8_ror_valid", 64'(ov8), 64'(1));
    check("w8_ror", 64'(r8), 64'h03);
    @(negedge clk);
    check("w8_sra", 64'(r8), 64'hFF);

    // Width 64: ROL of 1 by 63.
    @(posedge clk);
    #1;
    v64 = 1'b1; a64 = 64'd1; sh64 = 6'd63; op64 = 3'b110;
    @(posedge clk);
    #1;
    v64 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("w64_rol_valid", 64'(ov64), 64'(1));
    check("w64_rol", r64, 64'h8000_0000_0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
